// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the main-memory port arbiter.
package mem_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arbState_t;

    // Requester indices into the one-hot grant/request vectors
    localparam int NUM_REQ  = 3;
    localparam int REQ_CPU  = 0;
    localparam int REQ_DISK = 1;
    localparam int REQ_SPY  = 2;

    // Pointer value that makes cpu the first choice of the rotating picker
    localparam logic [NUM_REQ-1:0] LAST_WIN_RESET = 3'b100;

    // Watchdog counter width; TIMEOUT must fit in it
    localparam int CNT_W = 8;

    // Read data returned when the memory never answers (sliced to DW)
    localparam logic [63:0] NXM_FILL = '1;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 3-way rotating-priority picker. Priority starts at the
// requester after the last winner (cpu -> disk -> spy -> cpu).
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // Pick the first active request in rotation order after last_i
    always_comb begin
        grant_o = '0;
        case (last_i)
            3'b001: begin
                if      (req_i[REQ_DISK]) grant_o = 3'b010;
                else if (req_i[REQ_SPY])  grant_o = 3'b100;
                else if (req_i[REQ_CPU])  grant_o = 3'b001;
            end
            3'b010: begin
                if      (req_i[REQ_SPY])  grant_o = 3'b100;
                else if (req_i[REQ_CPU])  grant_o = 3'b001;
                else if (req_i[REQ_DISK]) grant_o = 3'b010;
            end
            default: begin
                if      (req_i[REQ_CPU])  grant_o = 3'b001;
                else if (req_i[REQ_DISK]) grant_o = 3'b010;
                else if (req_i[REQ_SPY])  grant_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory port between cpu, disk and spy
// requesters, runs one memory cycle per grant and turns a missing memory
// ack into an NXM error completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cpu_req_i,
    input  logic          cpu_wr_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic          cpu_err_o,
    input  logic          disk_req_i,
    input  logic          disk_wr_i,
    input  logic [AW-1:0] disk_addr_i,
    input  logic [DW-1:0] disk_wdata_i,
    output logic          disk_ack_o,
    output logic          disk_err_o,
    input  logic          spy_req_i,
    input  logic          spy_wr_i,
    input  logic [AW-1:0] spy_addr_i,
    input  logic [DW-1:0] spy_wdata_i,
    output logic          spy_ack_o,
    output logic          spy_err_o,
    output logic [DW-1:0] rdata_o,
    output logic [2:0]    grant_o,
    output logic          busy_o,
    output logic          mem_req_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    arbState_t          state_q,    state_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [NUM_REQ-1:0] lastWin_q,  lastWin_d;
    logic               memReq_q,   memReq_d;
    logic               memWr_q,    memWr_d;
    logic [AW-1:0]      memAddr_q,  memAddr_d;
    logic [DW-1:0]      memWdata_q, memWdata_d;
    logic [DW-1:0]      rdata_q,    rdata_d;
    logic               nxm_q,      nxm_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    logic [NUM_REQ-1:0] reqVec;
    logic [NUM_REQ-1:0] winner;
    logic               selWr;
    logic [AW-1:0]      selAddr;
    logic [DW-1:0]      selWdata;
    logic               doneCycle;

    assign reqVec[REQ_CPU]  = cpu_req_i;
    assign reqVec[REQ_DISK] = disk_req_i;
    assign reqVec[REQ_SPY]  = spy_req_i;

    mem_arb_rr uRr (
        .req_i   (reqVec),
        .last_i  (lastWin_q),
        .grant_o (winner)
    );

    // Route the winning requester's command fields toward the latches
    always_comb begin
        selWr    = cpu_wr_i;
        selAddr  = cpu_addr_i;
        selWdata = cpu_wdata_i;
        if (winner[REQ_DISK]) begin
            selWr    = disk_wr_i;
            selAddr  = disk_addr_i;
            selWdata = disk_wdata_i;
        end else if (winner[REQ_SPY]) begin
            selWr    = spy_wr_i;
            selAddr  = spy_addr_i;
            selWdata = spy_wdata_i;
        end
    end

    // Next-state logic: arbitrate, issue, wait with watchdog, complete
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        lastWin_d  = lastWin_q;
        memReq_d   = memReq_q;
        memWr_d    = memWr_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
        nxm_d      = nxm_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|reqVec) begin
                    grant_d    = winner;
                    memWr_d    = selWr;
                    memAddr_d  = selAddr;
                    memWdata_d = selWdata;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                memReq_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    memReq_d = 1'b0;
                    nxm_d    = 1'b0;
                    if (!memWr_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    memReq_d = 1'b0;
                    nxm_d    = 1'b1;
                    if (!memWr_q) begin
                        rdata_d = NXM_FILL[DW-1:0];
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                lastWin_d = grant_q;
                grant_d   = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops mem_req immediately
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            lastWin_q  <= LAST_WIN_RESET;
            memReq_q   <= 1'b0;
            memWr_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata_q    <= '0;
            nxm_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            lastWin_q  <= lastWin_d;
            memReq_q   <= memReq_d;
            memWr_q    <= memWr_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
            nxm_q      <= nxm_d;
            cnt_q      <= cnt_d;
        end
    end

    assign doneCycle   = (state_q == ST_DONE);
    assign cpu_ack_o   = doneCycle & grant_q[REQ_CPU];
    assign disk_ack_o  = doneCycle & grant_q[REQ_DISK];
    assign spy_ack_o   = doneCycle & grant_q[REQ_SPY];
    assign cpu_err_o   = cpu_ack_o & nxm_q;
    assign disk_err_o  = disk_ack_o & nxm_q;
    assign spy_err_o   = spy_ack_o & nxm_q;
    assign rdata_o     = rdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_req_o   = memReq_q;
    assign mem_wr_o    = memWr_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between three requesters: CPU memory control (cpu), disk DMA (disk) and the debug/spy interface (spy). Picks one requester with rotating priority, latches its address/data, runs one memory cycle, returns read data and a one-cycle ack. A watchdog converts a missing memory ack into a non-existent-memory (NXM) error completion. Sits between the CPU memory-control logic and the memory controller.

Parameters:
AW, 22, address width in words
DW, 32, data width
TIMEOUT, 255, cycles in WAIT before NXM is declared (1..255; counter is 8 bits)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
cpu_req / disk_req / spy_req  in  1 each  request; held high until matching ack
cpu_wr / disk_wr / spy_wr  in  1 each  1 = write, 0 = read; valid with req
cpu_addr / disk_addr / spy_addr  in  AW each  word address; valid with req
cpu_wdata / disk_wdata / spy_wdata  in  DW each  write data; valid with req
cpu_ack / disk_ack / spy_ack  out  1 each  one-cycle completion pulse
cpu_err / disk_err / spy_err  out  1 each  NXM flag, valid only with ack
rdata  out  DW  read data for the acked requester, valid with ack
grant  out  3  one-hot owner {spy,disk,cpu}; 0 when idle
busy  out  1  high in any state other than IDLE
mem_req  out  1  memory cycle request, held until mem_ack or timeout
mem_wr  out  1  write strobe to memory
mem_addr  out  AW  latched address
mem_wdata  out  DW  latched write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion pulse

Behaviour:
- Reset (async): state IDLE, grant=0, busy=0, mem_req=0, all acks/errs=0, rdata=0, mem_addr/mem_wdata/mem_wr=0, timeout counter=0, last-winner pointer=cpu. mem_req drops immediately on reset assertion, even mid-cycle.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: samples reqs. If any high, pick winner by rotating priority starting after last winner (order cpu->disk->spy->cpu). Register grant, mem_addr/mem_wdata/mem_wr from winner; go ISSUE. No req: stay.
- ISSUE: mem_req=1; clear counter; go WAIT.
- WAIT: mem_req=1. On mem_ack: latch rdata=mem_rdata (reads; writes leave rdata unchanged), err=0, go DONE. Else counter increments; when counter reaches TIMEOUT without ack: rdata=all ones on reads, err=1, go DONE. mem_ack and timeout in same cycle: ack wins, err=0.
- DONE: mem_req=0; winner's ack=1 (and err if NXM) for exactly this cycle; update last-winner pointer; grant cleared on exit; go IDLE.
- Latency: req seen in IDLE cycle N -> mem_req high from N+2 -> ack in the cycle after mem_ack. Minimum request-to-ack 4 cycles with 1-cycle memory.
- Requester inputs sampled only in IDLE; changes during ISSUE/WAIT/DONE are ignored (data latched). A req dropped before ack is not cancelled; the cycle completes and ack is still pulsed.
- mem_ack outside WAIT (late ack after timeout) is ignored.
- Requester still high in the IDLE after its ack is a new request.
- Fairness: with all three requesting continuously, grants rotate cpu, disk, spy, cpu...; no requester waits more than two other cycles.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT, DONE), requester index constants (CPU=0, DISK=1, SPY=2), NXM read value.
- One sub-module: mem_arb_rr, a 3-way rotating-priority picker (req[2:0], last[2:0] -> onehot winner). Pure combinational, reusable for bus arbitration elsewhere.

Test Plan:
- Single cpu read addr 22'h001234, memory acks after 3 cycles with 32'hDEADBEEF -> mem_addr=22'h001234, mem_wr=0, cpu_ack pulse 1 cycle, rdata=32'hDEADBEEF, cpu_err=0, grant returns 0.
- disk write addr 22'h000010 data 32'h0000ABCD -> mem_wr=1, mem_wdata=32'h0000ABCD, disk_ack pulse, rdata unchanged.
- All three requests held from same cycle, 1-cycle memory -> grant order cpu, disk, spy, cpu; each ack in that order, no ack overlaps.
- spy read, memory never acks, TIMEOUT=255 -> mem_req high for 255 WAIT cycles then drops; spy_ack=1, spy_err=1, rdata=32'hFFFFFFFF; mem_ack 2 cycles later ignored (no ack, state IDLE).
- mem_ack on exact timeout cycle -> err=0, rdata=mem_rdata.
- Assert reset during WAIT -> mem_req, busy, grant go 0 without clock edge; after release, pending cpu_req is granted fresh from IDLE.
